alu_cluster: RTL and testbench

Dual-lane execution unit sitting on the consumer side of the reservation-station dispatch interface. It accepts one calculation task per lane from the RS, computes a 32-bit result, and broadcasts `done/value/tag` back to the RS (and ROB) for wake-up and forwarding. Simple ops complete in one cycle; shifts run iteratively, up to 8 bits per cycle, so latency varies. Both lanes are flushed by `clear_signal` on a misprediction.

---
 rtl/alu_cluster.sv | 223 ++++++++++++++++++++++
 tb/tb_alu_cluster.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_cluster.sv
// alu_cluster: dual-lane execution unit fed by the reservation-station dispatch
// interface. Each lane captures one task while idle, computes a 32-bit result
// (one cycle for simple ops, up to 8 shift bits per cycle for shifts) and
// strobes done/value/tag for one cycle for RS/ROB wake-up and forwarding.
//
// Ports (per lane N = 1, 2):
//   clk_in, rst_in (async, active-high), rdy_in (global hold), clear_signal (flush)
//   busy_alu_N, opcode_alu_N, lhs_alu_N, rhs_alu_N, rd_tag_alu_N   task inputs
//   done_alu_N, value_alu_N, tag_alu_N, lane_idle_N                 registered outputs

// One execution lane: IDLE -> EXEC (-> EXEC ...) -> DONE -> IDLE.
module alu_lane #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_in,
   input  logic                 busy_in,
   input  logic [3:0]           opcode_in,
   input  logic [31:0]          lhs_in,
   input  logic [31:0]          rhs_in,
   input  logic [ROB_WIDTH-1:0] tag_in,
   output logic                 done_out,
   output logic [31:0]          value_out,
   output logic [ROB_WIDTH-1:0] tag_out,
   output logic                 idle_out
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [31:0]          lhs_q, lhs_d, rhs_q, rhs_d;
   logic [31:0]          acc_q, acc_d;
   logic [4:0]           rem_q, rem_d;
   logic [ROB_WIDTH-1:0] ctag_q, ctag_d, tag_q, tag_d;
   logic                 done_q, done_d;
   logic [31:0]          value_q, value_d;

   logic                 is_shift;
   logic [3:0]           k;
   logic [31:0]          shift_res, simple_res;

   assign is_shift = (op_q == 4'd2) || (op_q == 4'd6) || (op_q == 4'd7);
   // Step size: at most 8 bits per cycle.
   assign k = (rem_q > 5'd8) ? 4'd8 : rem_q[3:0];

   always_comb begin
      case (op_q)
         4'd2:    shift_res = acc_q << k;
         4'd6:    shift_res = acc_q >> k;
         default: shift_res = 32'($signed(acc_q) >>> k);
      endcase
   end

   always_comb begin
      case (op_q)
         4'd0:    simple_res = lhs_q + rhs_q;
         4'd1:    simple_res = lhs_q - rhs_q;
         4'd3:    simple_res = {31'd0, $signed(lhs_q) < $signed(rhs_q)};
         4'd4:    simple_res = {31'd0, lhs_q < rhs_q};
         4'd5:    simple_res = lhs_q ^ rhs_q;
         4'd8:    simple_res = lhs_q | rhs_q;
         4'd9:    simple_res = lhs_q & rhs_q;
         4'd10:   simple_res = {31'd0, lhs_q == rhs_q};
         4'd11:   simple_res = {31'd0, lhs_q != rhs_q};
         4'd12:   simple_res = {31'd0, $signed(lhs_q) >= $signed(rhs_q)};
         4'd13:   simple_res = {31'd0, lhs_q >= rhs_q};
         4'd14:   simple_res = rhs_q;
         default: simple_res = 32'd0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lhs_d   = lhs_q;
      rhs_d   = rhs_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      ctag_d  = ctag_q;
      tag_d   = tag_q;
      done_d  = done_q;
      value_d = value_q;
      if (rdy_in) begin
         if (clear_in) begin
            // Flush wins over capture and completion on the same edge.
            state_d = S_IDLE;
            done_d  = 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  done_d = 1'b0;
                  if (busy_in) begin
                     op_d    = opcode_in;
                     lhs_d   = lhs_in;
                     rhs_d   = rhs_in;
                     ctag_d  = tag_in;
                     acc_d   = lhs_in;
                     rem_d   = rhs_in[4:0];
                     state_d = S_EXEC;
                  end
               end
               S_EXEC: begin
                  if (is_shift && (rem_q != 5'd0)) begin
                     acc_d = shift_res;
                     rem_d = rem_q - {1'b0, k};
                  end else begin
                     value_d = is_shift ? acc_q : simple_res;
                     tag_d   = ctag_q;
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
               S_DONE: begin
                  // busy is still high for the finished task here; ignore it.
                  done_d  = 1'b0;
                  state_d = S_IDLE;
               end
               default: state_d = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         lhs_q   <= '0;
         rhs_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         ctag_q  <= '0;
         tag_q   <= '0;
         done_q  <= 1'b0;
         value_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         lhs_q   <= lhs_d;
         rhs_q   <= rhs_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         ctag_q  <= ctag_d;
         tag_q   <= tag_d;
         done_q  <= done_d;
         value_q <= value_d;
      end
   end

   assign done_out  = done_q;
   assign value_out = value_q;
   assign tag_out   = tag_q;
   assign idle_out  = (state_q == S_IDLE);
endmodule

module alu_cluster #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_signal,
   input  logic                 busy_alu_1,
   input  logic                 busy_alu_2,
   input  logic [3:0]           opcode_alu_1,
   input  logic [3:0]           opcode_alu_2,
   input  logic [31:0]          lhs_alu_1,
   input  logic [31:0]          lhs_alu_2,
   input  logic [31:0]          rhs_alu_1,
   input  logic [31:0]          rhs_alu_2,
   input  logic [ROB_WIDTH-1:0] rd_tag_alu_1,
   input  logic [ROB_WIDTH-1:0] rd_tag_alu_2,
   output logic                 done_alu_1,
   output logic                 done_alu_2,
   output logic [31:0]          value_alu_1,
   output logic [31:0]          value_alu_2,
   output logic [ROB_WIDTH-1:0] tag_alu_1,
   output logic [ROB_WIDTH-1:0] tag_alu_2,
   output logic                 lane_idle_1,
   output logic                 lane_idle_2
);
   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0]                busy_v, done_v, idle_v;
   logic [NUM_LANES-1:0][3:0]           op_v;
   logic [NUM_LANES-1:0][31:0]          lhs_v, rhs_v, value_v;
   logic [NUM_LANES-1:0][ROB_WIDTH-1:0] rtag_v, tag_v;

   assign busy_v = {busy_alu_2, busy_alu_1};
   assign op_v   = {opcode_alu_2, opcode_alu_1};
   assign lhs_v  = {lhs_alu_2, lhs_alu_1};
   assign rhs_v  = {rhs_alu_2, rhs_alu_1};
   assign rtag_v = {rd_tag_alu_2, rd_tag_alu_1};

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      alu_lane #(.ROB_WIDTH(ROB_WIDTH)) u_lane (
         .clk_in    (clk_in),
         .rst_in    (rst_in),
         .rdy_in    (rdy_in),
         .clear_in  (clear_signal),
         .busy_in   (busy_v[i]),
         .opcode_in (op_v[i]),
         .lhs_in    (lhs_v[i]),
         .rhs_in    (rhs_v[i]),
         .tag_in    (rtag_v[i]),
         .done_out  (done_v[i]),
         .value_out (value_v[i]),
         .tag_out   (tag_v[i]),
         .idle_out  (idle_v[i])
      );
   end

   assign done_alu_1  = done_v[0];
   assign done_alu_2  = done_v[1];
   assign value_alu_1 = value_v[0];
   assign value_alu_2 = value_v[1];
   assign tag_alu_1   = tag_v[0];
   assign tag_alu_2   = tag_v[1];
   assign lane_idle_1 = idle_v[0];
   assign lane_idle_2 = idle_v[1];
endmodule

// File: tb/tb_alu_cluster.sv
// Self-checking bench for alu_cluster: directed cases plus randomized tasks,
// checked against a behavioural model of results and latencies.
module tb_alu_cluster;
   logic              clk = 1'b0;
   logic              rst, rdy, clr;
   logic [1:0]        busy;
   logic [1:0][3:0]   opc, tgi;
   logic [1:0][31:0]  lhs, rhs;
   logic              d1, d2, i1, i2;
   logic [31:0]       v1, v2;
   logic [3:0]        t1, t2;
   logic [1:0]        done, idle;
   logic [1:0][31:0]  val;
   logic [1:0][3:0]   tgo;
   int                n_chk = 0;
   int                n_fail = 0;

   assign done = {d2, d1};
   assign idle = {i2, i1};
   assign val  = {v2, v1};
   assign tgo  = {t2, t1};

   always #5 clk = ~clk;

   alu_cluster #(.ROB_WIDTH(4)) dut (
      .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_signal(clr),
      .busy_alu_1(busy[0]), .busy_alu_2(busy[1]),
      .opcode_alu_1(opc[0]), .opcode_alu_2(opc[1]),
      .lhs_alu_1(lhs[0]), .lhs_alu_2(lhs[1]),
      .rhs_alu_1(rhs[0]), .rhs_alu_2(rhs[1]),
      .rd_tag_alu_1(tgi[0]), .rd_tag_alu_2(tgi[1]),
      .done_alu_1(d1), .done_alu_2(d2),
      .value_alu_1(v1), .value_alu_2(v2),
      .tag_alu_1(t1), .tag_alu_2(t2),
      .lane_idle_1(i1), .lane_idle_2(i2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int unsigned s = b[4:0];
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << s;
         4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:  return (a < b) ? 32'd1 : 32'd0;
         4'd5:  return a ^ b;
         4'd6:  return a >> s;
         4'd7:  return $signed(a) >>> s;
         4'd8:  return a | b;
         4'd9:  return a & b;
         4'd10: return (a == b) ? 32'd1 : 32'd0;
         4'd11: return (a != b) ? 32'd1 : 32'd0;
         4'd12: return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
         4'd13: return (a >= b) ? 32'd1 : 32'd0;
         4'd14: return b;
         default: return 32'd0;
      endcase
   endfunction

   // Edges from capture to done.
   function automatic int latency(input logic [3:0] op, input logic [31:0] b);
      if (op == 4'd2 || op == 4'd6 || op == 4'd7) return 1 + (int'(b[4:0]) + 7) / 8;
      return 1;
   endfunction

   // Issue on the enabled lanes, then watch 14 edges. stall_len>0 drops rdy
   // for that many edges right after capture; clr_edge>0 flushes on that edge
   // after capture and then no done may appear.
   task automatic run(input logic [1:0] en, input logic [1:0][3:0] op,
                      input logic [1:0][31:0] a, input logic [1:0][31:0] b,
                      input logic [1:0][3:0] tg, input int stall_len, input int clr_edge);
      int seen [2];
      int lat [2];
      logic [31:0] ev [2];
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         busy[l] = en[l]; opc[l] = op[l]; lhs[l] = a[l]; rhs[l] = b[l]; tgi[l] = tg[l];
         ev[l]   = model(op[l], a[l], b[l]);
         lat[l]  = latency(op[l], b[l]) + stall_len;
         seen[l] = -1;
      end
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (stall_len > 0 && c == 0) rdy = 1'b0;
         if (stall_len > 0 && c == stall_len) rdy = 1'b1;
         if (clr_edge > 0 && c == clr_edge - 1) begin clr = 1'b1; busy = 2'b00; end
         if (clr_edge > 0 && c == clr_edge) clr = 1'b0;
         for (int l = 0; l < 2; l++) begin
            if (done[l]) begin
               if (!en[l] || seen[l] >= 0 || clr_edge > 0) check("spurious_done", 32'd1, 32'd0);
               else begin
                  seen[l] = c;
                  check("latency", 32'(c), 32'(lat[l]));
                  check("value", val[l], ev[l]);
                  check("tag", 32'(tgo[l]), 32'(tg[l]));
               end
               busy[l] = 1'b0;  // RS retires busy once done is seen
            end
         end
      end
      for (int l = 0; l < 2; l++) begin
         if (en[l] && clr_edge == 0 && seen[l] < 0) check("timeout_no_done", 32'd0, 32'd1);
         if (en[l]) check("idle_after", 32'(idle[l]), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; clr = 1'b0; busy = '0; opc = '0; lhs = '0; rhs = '0; tgi = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         check("rst_done", 32'(done[l]), 32'd0);
         check("rst_value", val[l], 32'd0);
         check("rst_tag", 32'(tgo[l]), 32'd0);
         check("rst_idle", 32'(idle[l]), 32'd1);
      end
      @(negedge clk); rst = 1'b0;

      // Directed cases; packed pairs are {lane2, lane1}.
      run(2'b01, {4'd0, 4'd0},  {32'd0, 32'hFFFFFFFF}, {32'd0, 32'd1}, {4'd0, 4'd5}, 0, 0);
      run(2'b10, {4'd7, 4'd0},  {32'h80000000, 32'd0}, {32'd31, 32'd0}, {4'd3, 4'd0}, 0, 0);
      run(2'b10, {4'd6, 4'd0},  {32'h80000000, 32'd0}, {32'd31, 32'd0}, {4'd9, 4'd0}, 0, 0);
      run(2'b01, {4'd0, 4'd2},  {32'd0, 32'd1}, {32'd0, 32'h23}, {4'd0, 4'd7}, 0, 0);
      run(2'b11, {4'd4, 4'd3},  {32'hFFFFFFFF, 32'hFFFFFFFF}, {32'd1, 32'd1}, {4'd2, 4'd1}, 0, 0);
      run(2'b11, {4'd11, 4'd12}, {32'd3, 32'd5}, {32'd3, 32'd5}, {4'd4, 4'd6}, 0, 0);
      run(2'b01, {4'd0, 4'd14}, {32'd0, 32'hDEADBEEF}, {32'd0, 32'h12345000}, {4'd0, 4'hA}, 0, 0);
      run(2'b11, {4'd5, 4'd1},  {32'hF0F0F0F0, 32'd3}, {32'h0FF00FF0, 32'd5}, {4'hE, 4'hF}, 0, 0);
      run(2'b11, {4'd2, 4'd6},  {32'h1, 32'hFFFFFFFF}, {32'd8, 32'd0}, {4'd1, 4'd2}, 0, 0);
      // Flush mid-shift, flush on a completion edge, stall during a shift.
      run(2'b01, {4'd0, 4'd2},  {32'd0, 32'h3}, {32'd0, 32'd24}, {4'd0, 4'd8}, 0, 1);
      run(2'b10, {4'd0, 4'd0},  {32'd7, 32'd0}, {32'd9, 32'd0}, {4'd3, 4'd0}, 0, 1);
      run(2'b01, {4'd0, 4'd2},  {32'd0, 32'h5}, {32'd0, 32'd16}, {4'd0, 4'hC}, 3, 0);

      // Reset mid-shift: outputs clear, lane idle, no done afterwards.
      @(negedge clk);
      busy[0] = 1'b1; opc[0] = 4'd7; lhs[0] = 32'h80000000; rhs[0] = 32'd31; tgi[0] = 4'd6;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b1; busy[0] = 1'b0; #1;
      check("midrst_done", 32'(done[0]), 32'd0);
      check("midrst_value", val[0], 32'd0);
      check("midrst_tag", 32'(tgo[0]), 32'd0);
      check("midrst_idle", 32'(idle[0]), 32'd1);
      @(negedge clk); rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (done[0]) check("done_after_rst", 32'd1, 32'd0);
      end

      // Randomized tasks; shift amounts drawn across the full 0..31 range.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]       en;
         logic [1:0][3:0]  op, tg;
         logic [1:0][31:0] a, b;
         en = 2'($urandom_range(1, 3));
         for (int l = 0; l < 2; l++) begin
            op[l] = 4'($urandom_range(0, 15));
            tg[l] = 4'($urandom_range(0, 15));
            a[l]  = $urandom;
            b[l]  = ($urandom_range(0, 3) == 0) ? a[l] : $urandom;
         end
         run(en, op, a, b, tg, 0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
